// File: rtl/arb_rr16.sv
// arb_rr16: sixteen-requester round-robin arbiter driving a one-hot grant and
// the 4-bit select of a shared 16:1 datapath mux. A grant lasts until done,
// until the owner drops its request, or until HOLD_MAX cycles have elapsed.
//
// Handshake: req[i] is a level request; once granted, requester i owns the
// datapath while active=1 and gnt[i]=1. A single-cycle done (or dropping
// req[i]) ends ownership at the next edge. There is no back-pressure. Every
// release is followed by at least one idle cycle so sel can settle.
module arb_rr16 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic [3:0]  sel,
  output logic        active,
  output logic        timeout,
  output logic        dbg_state
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  state_e      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [15:0] gnt_q, gnt_d;
  logic [3:0]  sel_q, sel_d;
  logic        active_q, active_d;
  logic        timeout_q, timeout_d;

  logic [3:0]  win_idx;
  logic        win_found;
  logic        rel_done, rel_drop, rel_limit, release_now;

  // Circular priority scan starting at ptr: first set request wins.
  always_comb begin
    logic [3:0] idx;
    win_idx   = ptr_q;
    win_found = 1'b0;
    idx       = ptr_q;
    for (int i = 0; i < 16; i++) begin
      idx = ptr_q + 4'(i);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Release conditions seen while a grant is held.
  always_comb begin
    rel_done    = done;
    rel_drop    = !req[sel_q];
    rel_limit   = (hold_cnt_q == HOLD_LIM);
    release_now = rel_done || rel_drop || rel_limit;
  end

  // Next-state and registered-output logic for the IDLE/GRANT machine.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    active_d   = active_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d    = ST_GRANT;
          sel_d      = win_idx;
          gnt_d      = 16'(1) << win_idx;
          active_d   = 1'b1;
          hold_cnt_d = 8'd1;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          state_d   = ST_IDLE;
          gnt_d     = '0;
          active_d  = 1'b0;
          ptr_d     = sel_q + 4'd1;
          // Only a pure hold-limit release is reported as a timeout.
          timeout_d = rel_limit && !rel_done && !rel_drop;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      sel_q      <= '0;
      active_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      active_q   <= active_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign active    = active_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_arb_rr16.sv
// tb_arb_rr16: directed cycle-by-cycle vectors for arb_rr16 (HOLD_MAX=4).
// The driver applies one cycle of inputs and queues the outputs expected after
// the next rising edge; the monitor pops and compares just after that edge.
module tb_arb_rr16;

  localparam int W = 23;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        active;
  logic        timeout;
  logic        dbg_state;

  always #5 clk = ~clk;

  arb_rr16 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .sel       (sel),
    .active    (active),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Entry: {gnt[15:0], sel[3:0], active, timeout, state}
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc_no = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_no, act, exp);
    end
  endtask

  // Monitor: compares one queued expectation just after each rising edge.
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    cyc_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("gnt",     gnt,                  e[22:7]);
      check("sel",     {12'd0, sel},         {12'd0, e[6:3]});
      check("active",  {15'd0, active},      {15'd0, e[2]});
      check("timeout", {15'd0, timeout},     {15'd0, e[1]});
      check("state",   {15'd0, dbg_state},   {15'd0, e[0]});
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic [15:0] r, input logic d, input logic rn,
                     input logic [15:0] eg, input int es, input logic ea,
                     input logic et);
    req   = r;
    done  = d;
    rst_n = rn;
    exp_q.push_back({eg, 4'(es), ea, et, ea});
    @(posedge clk);
    #2;
  endtask

  initial begin
    req = '0; done = 1'b0; rst_n = 1'b0;

    // Reset with everything asserted: outputs stay cleared.
    cyc(16'hFFFF, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 1'b0);
    cyc(16'hFFFF, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 1'b0);
    // First grant after reset goes to 0, then released by done.
    cyc(16'hFFFF, 1'b1, 1'b1, 16'h0001, 0, 1'b1, 1'b0);
    cyc(16'hFFFF, 1'b1, 1'b1, 16'h0000, 0, 1'b0, 1'b0);

    // Full rotation: 1,2,...,15,0 with one idle cycle between grants.
    for (int k = 1; k <= 16; k++) begin
      cyc(16'hFFFF, 1'b1, 1'b1, 16'(1) << (k % 16), k % 16, 1'b1, 1'b0);
      cyc(16'hFFFF, 1'b1, 1'b1, 16'h0000, k % 16, 1'b0, 1'b0);
    end

    // Wrap-around: pointer at 1, requesters 0 and 15 alternate 15,0,15,0.
    for (int k = 0; k < 2; k++) begin
      cyc(16'h8001, 1'b1, 1'b1, 16'h8000, 15, 1'b1, 1'b0);
      cyc(16'h8001, 1'b1, 1'b1, 16'h0000, 15, 1'b0, 1'b0);
      cyc(16'h8001, 1'b1, 1'b1, 16'h0001, 0,  1'b1, 1'b0);
      cyc(16'h8001, 1'b1, 1'b1, 16'h0000, 0,  1'b0, 1'b0);
    end

    // Single requester 5: done in the 3rd grant cycle, then re-grant.
    cyc(16'h0020, 1'b0, 1'b1, 16'h0020, 5, 1'b1, 1'b0);
    cyc(16'h0020, 1'b0, 1'b1, 16'h0020, 5, 1'b1, 1'b0);
    cyc(16'h0020, 1'b0, 1'b1, 16'h0020, 5, 1'b1, 1'b0);
    cyc(16'h0020, 1'b1, 1'b1, 16'h0000, 5, 1'b0, 1'b0);
    cyc(16'h0020, 1'b0, 1'b1, 16'h0020, 5, 1'b1, 1'b0);
    cyc(16'h0020, 1'b1, 1'b1, 16'h0000, 5, 1'b0, 1'b0);

    // Request drop: requester 7 drops in its 2nd grant cycle, no timeout.
    cyc(16'h0080, 1'b0, 1'b1, 16'h0080, 7, 1'b1, 1'b0);
    cyc(16'h0080, 1'b0, 1'b1, 16'h0080, 7, 1'b1, 1'b0);
    cyc(16'h0000, 1'b0, 1'b1, 16'h0000, 7, 1'b0, 1'b0);
    cyc(16'h0000, 1'b0, 1'b1, 16'h0000, 7, 1'b0, 1'b0);

    // Mid-grant reset: pointer at 8 picks 10; reset clears, then 3 wins.
    cyc(16'h0408, 1'b0, 1'b1, 16'h0400, 10, 1'b1, 1'b0);
    cyc(16'h0408, 1'b0, 1'b1, 16'h0400, 10, 1'b1, 1'b0);
    cyc(16'h0408, 1'b0, 1'b0, 16'h0000, 0,  1'b0, 1'b0);
    cyc(16'h0408, 1'b0, 1'b1, 16'h0008, 3,  1'b1, 1'b0);
    cyc(16'h0408, 1'b1, 1'b1, 16'h0000, 3,  1'b0, 1'b0);

    // Timeout with HOLD_MAX=4: reset pointer, then 3 / 8 / 3.
    cyc(16'h0108, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cyc(16'h0108, 1'b0, 1'b1, 16'h0008, 3, 1'b1, 1'b0);
    cyc(16'h0108, 1'b0, 1'b1, 16'h0000, 3, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cyc(16'h0108, 1'b0, 1'b1, 16'h0100, 8, 1'b1, 1'b0);
    cyc(16'h0108, 1'b0, 1'b1, 16'h0000, 8, 1'b0, 1'b1);
    cyc(16'h0108, 1'b0, 1'b1, 16'h0008, 3, 1'b1, 1'b0);

    // Hold limit coinciding with done: single release, timeout suppressed.
    for (int k = 0; k < 3; k++) cyc(16'h0108, 1'b0, 1'b1, 16'h0008, 3, 1'b1, 1'b0);
    cyc(16'h0108, 1'b1, 1'b1, 16'h0000, 3, 1'b0, 1'b0);
    // done in idle with no request is ignored.
    cyc(16'h0000, 1'b1, 1'b1, 16'h0000, 3, 1'b0, 1'b0);

    // Every queued expectation must have been consumed.
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
